// File: rtl/fb_loader.sv
// -----------------------------------------------------------------------------
// fb_loader
//
// Framebuffer writer for the 64x64 LED panel driver. Takes a byte stream of
// RGB444 top/bottom pixel pairs over a valid/ready handshake, repacks each
// pair into the panel's bit-plane word and issues one framebuffer write per
// pair. Three stream bytes per word:
//   b0 = {R_t, G_t}, b1 = {B_t, R_b}, b2 = {G_b, B_b}
// and plane i of the word is {R_t[i], G_t[i], B_t[i], R_b[i], G_b[i], B_b[i]}.
//
// Optional feature: define FB_LOADER_CHECKSUM_EN to accumulate an 8-bit XOR
// of every data byte in a frame and consume one trailing checksum byte after
// the last write of the frame. Without it, chk_err is tied low.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   sof            start-of-frame pulse; resynchronises address and byte phase
//   in_data        stream byte
//   in_valid       in_data valid
//   in_ready       loader can accept a byte (low while writing and in reset)
//   mem_w_address  framebuffer word address {row, col}
//   mem_w_data     bit-plane packed word
//   we_a           write strobe, one cycle per word
//   frame_done     one-cycle pulse when a frame completes
//   busy           high from first accepted byte of a frame until frame_done
//   chk_err        checksum mismatch flag, held until sof or rst
// -----------------------------------------------------------------------------
module fb_loader #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            sof,
    input  logic [7:0]                                      in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    output logic [$clog2(NUM_COLS)+$clog2(NUM_ROWS/2)-1:0]  mem_w_address,
    output logic [6*BIT_DEPTH-1:0]                          mem_w_data,
    output logic                                            we_a,
    output logic                                            frame_done,
    output logic                                            busy,
    output logic                                            chk_err
);

    localparam int ADDR_W = $clog2(NUM_COLS) + $clog2(NUM_ROWS / 2);
    localparam int DATA_W = 6 * BIT_DEPTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COLS * (NUM_ROWS / 2) - 1);

    typedef enum logic [2:0] {
        S_B0,   // waiting for {R_t, G_t}
        S_B1,   // waiting for {B_t, R_b}
        S_B2,   // waiting for {G_b, B_b}
        S_WR,   // write cycle, input stalled
        S_CHK   // waiting for trailing checksum byte
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        byte0;
    logic [7:0]        byte1;
    logic              accept;
    logic              take_b0;
    logic              take_b1;
    logic              take_b2;
    logic              last_wr;
    logic              frame_end;

    // Plane i collects bit i of each of the six colour nibbles.
    function automatic logic [DATA_W-1:0] pack_word(input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < BIT_DEPTH; i++) begin
            w[6*i +: 6] = {b0[4+i], b0[i], b1[4+i], b1[i], b2[4+i], b2[i]};
        end
        return w;
    endfunction

    assign in_ready = !rst && (state != S_WR);
    assign accept   = in_valid && in_ready;

    // A byte accepted together with sof always opens a new pair, whatever
    // phase the loader was in.
    assign take_b0 = accept && (sof || state == S_B0);
    assign take_b1 = accept && !sof && (state == S_B1);
    assign take_b2 = accept && !sof && (state == S_B2);
    assign last_wr = (state == S_WR) && (addr == LAST_ADDR);

`ifdef FB_LOADER_CHECKSUM_EN
    logic take_chk;
    assign take_chk  = accept && !sof && (state == S_CHK);
    assign frame_end = take_chk;
`else
    assign frame_end = last_wr;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_B0:    if (accept) state_nxt = S_B1;
            S_B1:    if (accept) state_nxt = S_B2;
            S_B2:    if (accept) state_nxt = S_WR;
`ifdef FB_LOADER_CHECKSUM_EN
            S_WR:    state_nxt = last_wr ? S_CHK : S_B0;
            S_CHK:   if (accept) state_nxt = S_B0;
`else
            S_WR:    state_nxt = S_B0;
`endif
            default: state_nxt = S_B0;
        endcase
        // In S_WR accept is low, so sof there lets the write finish and lands in S_B0.
        if (sof) begin
            state_nxt = accept ? S_B1 : S_B0;
        end
    end

    // -------------------------------------------------------------------------
    // State, address and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= S_B0;
            addr          <= '0;
            mem_w_address <= '0;
            mem_w_data    <= '0;
            we_a          <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state      <= state_nxt;
            we_a       <= 1'b0;
            frame_done <= frame_end;

            if (take_b2) begin
                mem_w_address <= addr;
                mem_w_data    <= pack_word(byte0, byte1, in_data);
                we_a          <= 1'b1;
            end

            if (sof) begin
                addr <= '0;
            end else if (state == S_WR) begin
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            end

            if (frame_end) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end else if (sof) begin
                busy <= 1'b0;
            end
        end
    end

    // NOTE: pair holding bytes need no reset; each is written before it is read.
    always_ff @(posedge clk) begin
        if (take_b0) byte0 <= in_data;
        if (take_b1) byte1 <= in_data;
    end

    // -------------------------------------------------------------------------
    // Frame checksum
    // -------------------------------------------------------------------------
`ifdef FB_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc <= '0;
            chk_err <= 1'b0;
        end else if (sof) begin
            chk_acc <= accept ? in_data : 8'h00;
            chk_err <= 1'b0;
        end else if (take_chk) begin
            chk_acc <= '0;
            if (in_data != chk_acc) chk_err <= 1'b1;
        end else if (accept) begin
            chk_acc <= chk_acc ^ in_data;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_loader.sv
// -----------------------------------------------------------------------------
// tb_fb_loader
//
// Directed sequence with randomized pixel bytes for fb_loader. Expected words
// come from a reference that decodes the six colour nibbles arithmetically
// and rebuilds each bit plane; expected addresses come from a pair counter.
// Build with FB_LOADER_CHECKSUM_EN defined to exercise the trailing checksum.
// -----------------------------------------------------------------------------
module tb_fb_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        sof;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] mem_w_address;
    logic [23:0] mem_w_data;
    logic        we_a;
    logic        frame_done;
    logic        busy;
    logic        chk_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [34:0] wr_q[$];
    int          fd_count = 0;

`ifdef FB_LOADER_CHECKSUM_EN
    bit          corrupt_chk = 1'b0;
`endif

    fb_loader dut (
        .clk           (clk),
        .rst           (rst),
        .sof           (sof),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_w_address (mem_w_address),
        .mem_w_data    (mem_w_data),
        .we_a          (we_a),
        .frame_done    (frame_done),
        .busy          (busy),
        .chk_err       (chk_err)
    );

    always #5 clk = ~clk;

    // Record every write and every frame_done pulse.
    always @(negedge clk) begin
        if (we_a === 1'b1) wr_q.push_back({mem_w_address, mem_w_data});
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: nibble decode and plane assembly with plain arithmetic.
    function automatic logic [23:0] model_word(input logic [7:0] b0,
                                               input logic [7:0] b1,
                                               input logic [7:0] b2);
        int rt, gt, bt, rb, gb, bb, w;
        rt = int'(b0) / 16;  gt = int'(b0) % 16;
        bt = int'(b1) / 16;  rb = int'(b1) % 16;
        gb = int'(b2) / 16;  bb = int'(b2) % 16;
        w  = 0;
        for (int i = 0; i < 4; i++) begin
            int plane;
            plane = ((rt >> i) & 1) * 32 + ((gt >> i) & 1) * 16 + ((bt >> i) & 1) * 8
                  + ((rb >> i) & 1) * 4  + ((gb >> i) & 1) * 2  + ((bb >> i) & 1);
            w += plane << (6 * i);
        end
        return 24'(w);
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited   = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_triplet(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int max_gap);
        send_byte(b0, $urandom_range(max_gap, 0));
        send_byte(b1, $urandom_range(max_gap, 0));
        send_byte(b2, $urandom_range(max_gap, 0));
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    // One whole frame with in_valid held high; writes checked as they occur.
    task automatic run_frame();
        logic [7:0] b0, b1, b2;
        int         n_bad;
`ifdef FB_LOADER_CHECKSUM_EN
        logic [7:0] csum;
        csum = 8'h00;
`endif
        n_bad = 0;
        wr_q.delete();
        fd_count = 0;
        for (int a = 0; a < 2048; a++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
`ifdef FB_LOADER_CHECKSUM_EN
            csum = csum ^ b0 ^ b1 ^ b2;
`endif
            send_triplet(b0, b1, b2, 0);
            if (we_a !== 1'b1 || mem_w_address !== 11'(a) ||
                mem_w_data !== model_word(b0, b1, b2)) n_bad++;
        end
        check("frame_write_mismatches", 32'(n_bad), 32'd0);
        check("frame_last_address", 32'(mem_w_address), 32'h7FF);
`ifdef FB_LOADER_CHECKSUM_EN
        send_byte(corrupt_chk ? ~csum : csum, 0);
        check("frame_done_after_chk_byte", 32'(frame_done), 32'd1);
        check("chk_err_after_frame", 32'(chk_err), 32'(corrupt_chk));
`else
        @(negedge clk);
        check("frame_done_after_last_write", 32'(frame_done), 32'd1);
`endif
        check("busy_low_at_frame_done", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("frame_done_pulse_count", 32'(fd_count), 32'd1);
        check("frame_write_count", 32'(wr_q.size()), 32'd2048);
    endtask

    initial begin
        logic [7:0] s0, s1, s2, s3, n0, n1, n2;
        logic [34:0] ent;
        int n_partial;

        rst      = 1'b1;
        sof      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("in_ready_during_reset", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_we_a", 32'(we_a), 32'd0);
        check("reset_address", 32'(mem_w_address), 32'd0);
        check("reset_data", 32'(mem_w_data), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_chk_err", 32'(chk_err), 32'd0);

        // Pure red top / pure red bottom pattern.
        send_triplet(8'hF0, 8'h0F, 8'h00, 0);
        check("wr1_we_a", 32'(we_a), 32'd1);
        check("wr1_address", 32'(mem_w_address), 32'h000);
        check("wr1_data", 32'(mem_w_data), 32'h924924);
        check("wr1_in_ready_low", 32'(in_ready), 32'd0);
        check("wr1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wr1_we_a_single", 32'(we_a), 32'd0);
        check("wr1_data_held", 32'(mem_w_data), 32'h924924);

        // Distinct nibbles back at address 0.
        pulse_sof();
        send_triplet(8'h12, 8'h34, 8'h56, 0);
        check("wr2_address", 32'(mem_w_address), 32'h000);
        check("wr2_data", 32'(mem_w_data), 32'h00766A);
        check("wr2_data_model", 32'(mem_w_data), 32'(model_word(8'h12, 8'h34, 8'h56)));

        // sof with a byte accepted in the same cycle after a stray byte.
        pulse_sof();
        wr_q.delete();
        s0 = 8'($urandom); s1 = 8'($urandom); s2 = 8'($urandom); s3 = 8'($urandom);
        n0 = 8'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
        send_triplet(s0, s1, s2, 0);
        send_byte(s3, 0);
        sof = 1'b1;
        send_byte(n0, 0);
        sof = 1'b0;
        send_byte(n1, 0);
        send_byte(n2, 0);
        check("sof_pair_address", 32'(mem_w_address), 32'h000);
        check("sof_pair_data", 32'(mem_w_data), 32'(model_word(n0, n1, n2)));
        @(negedge clk);
        #1;
        check("sof_write_count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() > 0) begin
            ent = wr_q[0];
            check("sof_first_write_data", 32'(ent[23:0]), 32'(model_word(s0, s1, s2)));
        end

        // Full frame, then the next pair wraps to address 0.
        pulse_sof();
        run_frame();
        n0 = 8'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
        send_triplet(n0, n1, n2, 0);
        check("wrap_address", 32'(mem_w_address), 32'h000);
        check("wrap_data", 32'(mem_w_data), 32'(model_word(n0, n1, n2)));

`ifdef FB_LOADER_CHECKSUM_EN
        // Corrupted trailing byte: flag sets and survives until sof.
        pulse_sof();
        corrupt_chk = 1'b1;
        run_frame();
        send_triplet(8'($urandom), 8'($urandom), 8'($urandom), 2);
        check("chk_err_held", 32'(chk_err), 32'd1);
        pulse_sof();
        check("chk_err_cleared_by_sof", 32'(chk_err), 32'd0);
`endif

        // Random gaps, then reset in the middle of a pair.
        pulse_sof();
        for (int t = 0; t < 5; t++) begin
            n0 = 8'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
            send_triplet(n0, n1, n2, 3);
            check("gap_address", 32'(mem_w_address), 32'(t));
            check("gap_data", 32'(mem_w_data), 32'(model_word(n0, n1, n2)));
        end
        n_partial = $urandom_range(2, 1);
        for (int k = 0; k < n_partial; k++) send_byte(8'($urandom), $urandom_range(2, 0));
        wr_q.delete();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        check("in_ready_low_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rst_no_partial_write", 32'(wr_q.size()), 32'd0);
        check("rst_we_a", 32'(we_a), 32'd0);
        check("rst_address", 32'(mem_w_address), 32'd0);
        check("rst_data", 32'(mem_w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        n0 = 8'($urandom); n1 = 8'($urandom); n2 = 8'($urandom);
        send_triplet(n0, n1, n2, 2);
        check("post_rst_address", 32'(mem_w_address), 32'h000);
        check("post_rst_data", 32'(mem_w_data), 32'(model_word(n0, n1, n2)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
